// File: rtl/axi_addr_arbiter_if.sv
// Address-channel bundle for axi_addr_arbiter: per-master request slices
// on one side, the single registered peripheral address channel on the other.
interface axi_addr_arbiter_if #(
   parameter int masters    = 4,
   parameter int width      = 22,
   parameter int id_bits    = 4,
   parameter int len_bits   = 8,
   parameter int size_bits  = 3,
   parameter int burst_bits = 2,
   parameter int lock_bits  = 1,
   parameter int cache_bits = 4,
   parameter int prot_bits  = 3
);
   // Requester side, master i at slice i.
   logic [masters-1:0]            M_VALID;
   logic [masters-1:0]            M_READY;
   logic [masters*id_bits-1:0]    M_ID;
   logic [masters*width-1:0]      M_ADDR;
   logic [masters*len_bits-1:0]   M_LEN;
   logic [masters*size_bits-1:0]  M_SIZE;
   logic [masters*burst_bits-1:0] M_BURST;
   logic [masters*lock_bits-1:0]  M_LOCK;
   logic [masters*cache_bits-1:0] M_CACHE;
   logic [masters*prot_bits-1:0]  M_PROT;

   // Peripheral side.
   logic [masters-1:0]    MASTER;
   logic [id_bits-1:0]    ID;
   logic [width-1:0]      ADDR;
   logic [len_bits-1:0]   LEN;
   logic [size_bits-1:0]  SIZE;
   logic [burst_bits-1:0] BURST;
   logic [lock_bits-1:0]  LOCK;
   logic [cache_bits-1:0] CACHE;
   logic [prot_bits-1:0]  PROT;
   logic                  VALID;
   logic                  READY;
   logic                  DONE;
   logic [3:0]            OUTSTANDING;
   logic                  ERR;

   modport slave (
      input  M_VALID, M_ID, M_ADDR, M_LEN, M_SIZE, M_BURST, M_LOCK, M_CACHE, M_PROT,
      input  READY, DONE,
      output M_READY, MASTER, ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT,
      output VALID, OUTSTANDING, ERR
   );

   modport master (
      output M_VALID, M_ID, M_ADDR, M_LEN, M_SIZE, M_BURST, M_LOCK, M_CACHE, M_PROT,
      output READY, DONE,
      input  M_READY, MASTER, ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT,
      input  VALID, OUTSTANDING, ERR
   );
endinterface

// File: rtl/axi_addr_arbiter.sv
// Round-robin arbiter sharing one peripheral address channel between several
// AXI address requesters, with a registered offer and an in-flight limit.
module axi_addr_arbiter #(
   parameter int masters         = 4,
   parameter int width           = 22,
   parameter int max_outstanding = 4,
   parameter int id_bits         = 4,
   parameter int len_bits        = 8,
   parameter int size_bits       = 3,
   parameter int burst_bits      = 2,
   parameter int lock_bits       = 1,
   parameter int cache_bits      = 4,
   parameter int prot_bits       = 3
) (
   input logic             CLK,
   input logic             RESETN,
   axi_addr_arbiter_if.slave bus
);

   localparam int idx_bits = (masters > 1) ? $clog2(masters) : 1;

   typedef enum logic {
      IDLE,
      OFFER
   } state_t;

   state_t              state, state_nxt;
   logic [idx_bits-1:0] last;
   logic [idx_bits-1:0] grant_idx;
   logic                grant_found;
   logic                grant_en;
   logic                accept;
   logic [3:0]          outstanding;
   logic                err;

   assign bus.VALID       = (state == OFFER);
   assign bus.OUTSTANDING = outstanding;
   assign bus.ERR         = err;

   // Rotating search: the master just after the last winner is looked at first.
   always_comb begin : search
      int cand;
      // NOTE: every variable gets a default before any conditional write, so
      // no path leaves a value unassigned and no latch is inferred.
      grant_idx   = last;
      grant_found = 1'b0;
      cand        = 0;
      for (int i = 1; i <= masters; i++) begin
         cand = int'(last) + i;
         if (cand >= masters) cand = cand - masters;
         if (!grant_found && bus.M_VALID[cand]) begin
            grant_found = 1'b1;
            grant_idx   = idx_bits'(cand);
         end
      end
   end

   always_comb begin : fsm_next
      state_nxt   = state;
      grant_en    = 1'b0;
      accept      = 1'b0;
      bus.M_READY = '0;
      case (state)
         IDLE: begin
            if (RESETN && grant_found && (outstanding < 4'(max_outstanding))) begin
               grant_en               = 1'b1;
               bus.M_READY[grant_idx] = 1'b1;
               state_nxt              = OFFER;
            end
         end
         OFFER: begin
            if (bus.READY) begin
               accept    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin : regs
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!RESETN) begin
         state       <= IDLE;
         last        <= idx_bits'(masters - 1);
         outstanding <= 4'd0;
         err         <= 1'b0;
         bus.MASTER  <= '0;
         bus.ID      <= '0;
         bus.ADDR    <= '0;
         bus.LEN     <= '0;
         bus.SIZE    <= '0;
         bus.BURST   <= '0;
         bus.LOCK    <= '0;
         bus.CACHE   <= '0;
         bus.PROT    <= '0;
      end else begin
         state <= state_nxt;

         if (grant_en) begin
            last       <= grant_idx;
            bus.MASTER <= masters'(1) << grant_idx;
            bus.ID     <= bus.M_ID   [grant_idx*id_bits    +: id_bits];
            bus.ADDR   <= bus.M_ADDR [grant_idx*width      +: width];
            bus.LEN    <= bus.M_LEN  [grant_idx*len_bits   +: len_bits];
            bus.SIZE   <= bus.M_SIZE [grant_idx*size_bits  +: size_bits];
            bus.BURST  <= bus.M_BURST[grant_idx*burst_bits +: burst_bits];
            bus.LOCK   <= bus.M_LOCK [grant_idx*lock_bits  +: lock_bits];
            bus.CACHE  <= bus.M_CACHE[grant_idx*cache_bits +: cache_bits];
            bus.PROT   <= bus.M_PROT [grant_idx*prot_bits  +: prot_bits];
         end

         // An accept and a completion in the same cycle cancel out.
         case ({accept, bus.DONE})
            2'b10: outstanding <= outstanding + 4'd1;
            2'b01: begin
               if (outstanding == 4'd0) err <= 1'b1;
               else                     outstanding <= outstanding - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Self-checking bench for axi_addr_arbiter: a transaction-level model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_axi_addr_arbiter;

   localparam int masters         = 4;
   localparam int width           = 22;
   localparam int max_outstanding = 4;
   localparam int id_bits         = 4;
   localparam int len_bits        = 8;
   localparam int size_bits       = 3;
   localparam int burst_bits      = 2;
   localparam int lock_bits       = 1;
   localparam int cache_bits      = 4;
   localparam int prot_bits       = 3;
   localparam int req_bits = id_bits + width + len_bits + size_bits + burst_bits
                           + lock_bits + cache_bits + prot_bits;

   logic CLK = 1'b0;
   logic RESETN;
   int   checks = 0;
   int   errors = 0;

   axi_addr_arbiter_if #(
      .masters(masters), .width(width), .id_bits(id_bits), .len_bits(len_bits),
      .size_bits(size_bits), .burst_bits(burst_bits), .lock_bits(lock_bits),
      .cache_bits(cache_bits), .prot_bits(prot_bits)
   ) bus ();

   axi_addr_arbiter #(
      .masters(masters), .width(width), .max_outstanding(max_outstanding),
      .id_bits(id_bits), .len_bits(len_bits), .size_bits(size_bits),
      .burst_bits(burst_bits), .lock_bits(lock_bits), .cache_bits(cache_bits),
      .prot_bits(prot_bits)
   ) dut (
      .CLK   (CLK),
      .RESETN(RESETN),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [req_bits-1:0] req_of(input int m);
      return {bus.M_ID[m*id_bits +: id_bits], bus.M_ADDR[m*width +: width],
              bus.M_LEN[m*len_bits +: len_bits], bus.M_SIZE[m*size_bits +: size_bits],
              bus.M_BURST[m*burst_bits +: burst_bits], bus.M_LOCK[m*lock_bits +: lock_bits],
              bus.M_CACHE[m*cache_bits +: cache_bits], bus.M_PROT[m*prot_bits +: prot_bits]};
   endfunction

   function automatic logic [req_bits-1:0] out_req();
      return {bus.ID, bus.ADDR, bus.LEN, bus.SIZE, bus.BURST, bus.LOCK, bus.CACHE, bus.PROT};
   endfunction

   function automatic int onehot_index(input logic [masters-1:0] v);
      int r = -1;
      for (int i = 0; i < masters; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Reference model: pending offer flag, round-robin pointer, in-flight count.
   bit                   mdl_pending = 1'b0;
   int                   mdl_last    = masters - 1;
   int                   mdl_out     = 0;
   bit                   mdl_err     = 1'b0;
   logic [masters-1:0]   mdl_master  = '0;
   logic [req_bits-1:0]  mdl_req     = '0;

   initial begin : model
      int                 w;
      bit                 acc;
      logic [masters-1:0] exp_ready;
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         exp_ready = '0;
         w         = -1;
         if (RESETN && !mdl_pending && mdl_out < max_outstanding)
            for (int k = 1; k <= masters; k++)
               if (w < 0 && bus.M_VALID[(mdl_last + k) % masters] === 1'b1)
                  w = (mdl_last + k) % masters;
         if (w >= 0) exp_ready[w] = 1'b1;

         check("m_ready",     bus.M_READY,     exp_ready);
         check("valid",       bus.VALID,       mdl_pending);
         check("master",      bus.MASTER,      mdl_master);
         check("fields",      out_req(),       mdl_req);
         check("outstanding", bus.OUTSTANDING, mdl_out);
         check("err",         bus.ERR,         mdl_err);

         if (!RESETN) begin
            mdl_pending = 1'b0;
            mdl_last    = masters - 1;
            mdl_out     = 0;
            mdl_err     = 1'b0;
            mdl_master  = '0;
            mdl_req     = '0;
         end else begin
            acc = mdl_pending && bus.READY;
            if (w >= 0) begin
               mdl_req     = req_of(w);
               mdl_master  = masters'(1) << w;
               mdl_last    = w;
               mdl_pending = 1'b1;
            end else if (acc) begin
               mdl_pending = 1'b0;
            end
            if (acc && !bus.DONE)      mdl_out++;
            else if (!acc && bus.DONE) begin
               if (mdl_out == 0) mdl_err = 1'b1;
               else              mdl_out--;
            end
         end
      end
   end

   // Inputs change only at posedge+1; DUT outputs are read at negedge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic at_neg();
      @(negedge CLK);
   endtask

   task automatic set_fields(input int m);
      bus.M_ID   [m*id_bits    +: id_bits]    = id_bits'($urandom);
      bus.M_ADDR [m*width      +: width]      = width'($urandom);
      bus.M_LEN  [m*len_bits   +: len_bits]   = len_bits'($urandom);
      bus.M_SIZE [m*size_bits  +: size_bits]  = size_bits'($urandom);
      bus.M_BURST[m*burst_bits +: burst_bits] = burst_bits'($urandom);
      bus.M_LOCK [m*lock_bits  +: lock_bits]  = lock_bits'($urandom);
      bus.M_CACHE[m*cache_bits +: cache_bits] = cache_bits'($urandom);
      bus.M_PROT [m*prot_bits  +: prot_bits]  = prot_bits'($urandom);
   endtask

   task automatic do_reset();
      RESETN      = 1'b0;
      bus.M_VALID = '0;
      bus.READY   = 1'b0;
      bus.DONE    = 1'b0;
      tick();
      tick();
      RESETN = 1'b1;
   endtask

   // One grant from master 0 followed by an immediate accept.
   task automatic xfer(input bit done_on_accept);
      bus.M_VALID = 4'b0001;
      set_fields(0);
      bus.READY = 1'b1;
      tick();
      bus.M_VALID = '0;
      bus.DONE    = done_on_accept;
      tick();
      bus.DONE = 1'b0;
   endtask

   task automatic pulse_done();
      bus.DONE = 1'b1;
      tick();
      bus.DONE = 1'b0;
   endtask

   initial begin : stimulus
      logic [width-1:0]    a2;
      logic [req_bits-1:0] held;
      logic [masters-1:0]  acc;
      bit                  was_accept;
      int                  order[$];
      int                  gcyc[$];
      int                  n;

      RESETN      = 1'b0;
      bus.M_VALID = '0;
      bus.READY   = 1'b0;
      bus.DONE    = 1'b0;
      for (int m = 0; m < masters; m++) set_fields(m);

      // Reset state, then a lone request from master 2.
      do_reset();
      at_neg();
      check("rst_valid", bus.VALID, 1'b0);
      check("rst_master", bus.MASTER, 4'b0000);
      check("rst_out", bus.OUTSTANDING, 4'd0);
      check("rst_err", bus.ERR, 1'b0);
      tick();
      bus.M_VALID = 4'b0100;
      set_fields(2);
      bus.READY = 1'b1;
      a2 = bus.M_ADDR[2*width +: width];
      at_neg();
      check("t1_mready", bus.M_READY, 4'b0100);
      tick();
      bus.M_VALID = '0;
      at_neg();
      check("t1_valid", bus.VALID, 1'b1);
      check("t1_master", bus.MASTER, 4'b0100);
      check("t1_addr", bus.ADDR, a2);
      tick();
      at_neg();
      check("t1_idle", bus.VALID, 1'b0);
      check("t1_out", bus.OUTSTANDING, 4'd1);
      tick();

      // All masters requesting, DONE one cycle after each accept.
      do_reset();
      bus.M_VALID = '1;
      bus.READY   = 1'b1;
      for (int c = 0; c < 12; c++) begin
         at_neg();
         acc = bus.M_READY;
         if (acc != '0) begin
            order.push_back(onehot_index(acc));
            gcyc.push_back(c);
         end
         check("t2_out_le1", bus.OUTSTANDING <= 4'd1, 1'b1);
         was_accept = bus.VALID && bus.READY;
         tick();
         for (int m = 0; m < masters; m++) if (acc[m]) set_fields(m);
         bus.DONE = was_accept;
      end
      bus.DONE = 1'b0;
      check("t2_grants", order.size() >= 5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("t2_order", (i < order.size()) ? order[i] : -1, i % masters);
         check("t2_spacing", (i < gcyc.size()) ? gcyc[i] : -1, 2 * i);
      end

      // In-flight limit with no completions, then one DONE frees a slot.
      do_reset();
      bus.M_VALID = '1;
      bus.READY   = 1'b1;
      n = 0;
      for (int c = 0; c < 14; c++) begin
         at_neg();
         acc = bus.M_READY;
         if (acc != '0) n++;
         tick();
         for (int m = 0; m < masters; m++) if (acc[m]) set_fields(m);
      end
      check("t3_accepts", n, max_outstanding);
      at_neg();
      check("t3_out_full", bus.OUTSTANDING, 4'd4);
      check("t3_blocked", bus.M_READY, 4'b0000);
      tick();
      bus.DONE = 1'b1;
      at_neg();
      check("t3_blocked_done", bus.M_READY, 4'b0000);
      tick();
      bus.DONE = 1'b0;
      at_neg();
      check("t3_out3", bus.OUTSTANDING, 4'd3);
      check("t3_regrant", bus.M_READY, 4'b0001);
      tick();

      // Stall: READY low for five offer cycles, accept on the sixth.
      do_reset();
      bus.M_VALID = '1;
      bus.READY   = 1'b0;
      held = req_of(0);
      at_neg();
      check("t4_grant", bus.M_READY, 4'b0001);
      tick();
      set_fields(0);
      for (int c = 0; c < 5; c++) begin
         at_neg();
         check("t4_hold_valid", bus.VALID, 1'b1);
         check("t4_hold_master", bus.MASTER, 4'b0001);
         check("t4_hold_fields", out_req(), held);
         check("t4_no_mready", bus.M_READY, 4'b0000);
         tick();
      end
      bus.READY = 1'b1;
      at_neg();
      check("t4_offer6", bus.VALID, 1'b1);
      tick();
      at_neg();
      check("t4_idle", bus.VALID, 1'b0);
      check("t4_next", bus.M_READY, 4'b0010);
      tick();

      // Coincident DONE/accept, then DONE on an empty counter.
      do_reset();
      xfer(1'b0);
      xfer(1'b0);
      at_neg();
      check("t5_out2", bus.OUTSTANDING, 4'd2);
      tick();
      xfer(1'b1);
      at_neg();
      check("t5_out2_coinc", bus.OUTSTANDING, 4'd2);
      tick();
      pulse_done();
      pulse_done();
      at_neg();
      check("t5_out0", bus.OUTSTANDING, 4'd0);
      check("t5_err0", bus.ERR, 1'b0);
      tick();
      pulse_done();
      at_neg();
      check("t5_err_set", bus.ERR, 1'b1);
      check("t5_out_stays0", bus.OUTSTANDING, 4'd0);
      tick();
      tick();
      tick();
      at_neg();
      check("t5_err_sticky", bus.ERR, 1'b1);
      tick();

      // Reset in the middle of an offer with three transactions in flight.
      xfer(1'b0);
      xfer(1'b0);
      xfer(1'b0);
      bus.M_VALID = '1;
      bus.READY   = 1'b0;
      tick();
      at_neg();
      check("t6_offer", bus.VALID, 1'b1);
      check("t6_out3", bus.OUTSTANDING, 4'd3);
      tick();
      RESETN = 1'b0;
      at_neg();
      check("t6_rst_mready", bus.M_READY, 4'b0000);
      tick();
      RESETN = 1'b1;
      at_neg();
      check("t6_valid0", bus.VALID, 1'b0);
      check("t6_out0", bus.OUTSTANDING, 4'd0);
      check("t6_err0", bus.ERR, 1'b0);
      check("t6_first", bus.M_READY, 4'b0001);
      tick();

      // Random traffic checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         at_neg();
         acc = bus.M_READY;
         tick();
         RESETN    = ($urandom_range(99) != 0);
         bus.READY = ($urandom_range(9) < 7);
         bus.DONE  = ($urandom_range(9) < 3);
         for (int m = 0; m < masters; m++) begin
            if (acc[m] || !bus.M_VALID[m]) begin
               bus.M_VALID[m] = ($urandom_range(1) == 1);
               set_fields(m);
            end else if ($urandom_range(19) == 0) begin
               bus.M_VALID[m] = 1'b0;
            end
         end
      end
      at_neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
